uart_rx_stream: RTL and testbench

//  Host-to-FPGA UART receiver: deserialises 8N1 frames on uart_rxd into bytes on an AXI-Stream master.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_stream_if.sv | 9 +
 rtl/axis_byte_fifo.sv | 56 +++++
 rtl/uart_rx_stream.sv | 155 +++++++++++++++
 tb/tb_uart_rx_stream.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART stream blocks.
// Provides the receiver state encoding and bit-period arithmetic.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_stream_if.sv
// Byte-wide AXI-Stream link (tdata/tvalid/tready) with master and slave views.
interface uart_rx_stream_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_byte_fifo.sv
// First-word-fall-through byte FIFO: tvalid the cycle after an accepted push; a push into a
// full FIFO is dropped (overrun pulse) unless a pop happens in the same cycle.
module axis_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_vld,
  input  logic [7:0]              push_dat,
  output logic                    overrun,
  uart_rx_stream_if.master        m_axis
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overrun_q, overrun_d;
  logic        full, empty, pop, accept;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop    = !empty && m_axis.tready;
  // A simultaneous pop frees the slot this push lands in.
  assign accept = push_vld && (!full || pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, accept};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
    overrun_d = push_vld && !accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
  end

  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = mem_q[rd_ptr_q[AW-1:0]];
  assign overrun       = overrun_q;

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver feeding a byte FIFO on an AXI-Stream master; byte pushed the cycle after
// the mid-stop sample, tvalid one cycle later; a full FIFO with no pop drops the byte (overrun).
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              uart_rxd,
  uart_rx_stream_if.master  m_axis,
  output logic              frame_err,
  output logic              overrun,
  output logic              rx_busy
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] MID_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] MID    = CW'(CPB / 2);
  localparam logic [CW-1:0] MID_P1 = CW'(CPB / 2 + 1);
  localparam logic [CW-1:0] LAST   = CW'(CPB - 1);

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [1:0]    vote_q, vote_d;
  logic [1:0]    sync_q, sync_d;
  logic [1:0]    flush_q, flush_d;
  logic          armed_q, armed_d;
  logic          push_q, push_d;
  logic          frame_err_q, frame_err_d;
  logic          rxd_s, voted;

  assign rxd_s = sync_q[1];
  assign voted = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxd_s) | (vote_q[0] & rxd_s);

  always_comb begin
    sync_d      = {sync_q[0], uart_rxd};
    // The preset synchroniser output is only trusted once two real samples have flowed through;
    // starts are armed by a genuine high so a line held low across reset is ignored.
    flush_d     = (flush_q == 2'd2) ? flush_q : flush_q + 2'd1;
    armed_d     = armed_q | ((flush_q == 2'd2) & rxd_s);
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    vote_d      = vote_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;

    if (cnt_q == MID_M1 || cnt_q == MID) begin
      vote_d = {vote_q[0], rxd_s};
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (armed_q && !rxd_s) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == MID && rxd_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (cnt_q == MID_P1) begin
          shreg_d = {voted, shreg_q[7:1]};
        end
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        // Leaving here at MID+1 lets the next start edge land in the back half of the stop bit.
        if (cnt_q == MID_P1) begin
          cnt_d = '0;
          if (voted) begin
            state_d = IDLE;
            push_d  = 1'b1;
          end else begin
            state_d     = BREAK;
            frame_err_d = 1'b1;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxd_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      vote_q      <= '0;
      sync_q      <= 2'b11;
      flush_q     <= '0;
      armed_q     <= 1'b0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      vote_q      <= vote_d;
      sync_q      <= sync_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
    end
  end

  axis_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (axi_aclk),
    .rst_n    (axi_aresetn),
    .push_vld (push_q),
    .push_dat (shreg_q),
    .overrun  (overrun),
    .m_axis   (m_axis)
  );

  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_stream.sv
// Scoreboarded bench for uart_rx_stream at 16 clocks per bit.
module tb_uart_rx_stream;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;
  logic frame_err, overrun, rx_busy;

  uart_rx_stream_if axis ();

  uart_rx_stream #(
    .CLK_HZ     (1_600_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (16)
  ) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .uart_rxd    (rxd),
    .m_axis      (axis),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  int         total     = 0;
  int         bad       = 0;
  int         ferr_seen = 0;
  int         ovr_seen  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat is popped against the scoreboard; pulses are tallied.
  always @(negedge clk) begin
    if (rst_n) begin
      if (axis.tvalid && axis.tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got 0x%0h want none", axis.tdata);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("beat", {24'd0, axis.tdata}, {24'd0, e});
        end
      end
      if (frame_err) ferr_seen++;
      if (overrun)   ovr_seen++;
    end
  end

  task automatic hold(input logic v, input int n);
    for (int k = 0; k < n; k++) begin
      rxd = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int glitch_bit);
    hold(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 16; k++) begin
        rxd = (i == glitch_bit && k == 8) ? 1'b0 : b[i];
        @(posedge clk);
        #1;
      end
    end
    hold(stop_bit, 16);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    axis.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid",    axis.tvalid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun",   overrun, 0);
    check("rst_busy",      rx_busy, 0);
    rst_n = 1'b1;
    hold(1'b1, 10);

    // Single frame and output latency.
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, -1);
      begin
        repeat (157) @(posedge clk);
        @(negedge clk);
        check("t1_tvalid_early", axis.tvalid, 0);
        @(negedge clk);
        check("t1_tvalid_rise", axis.tvalid, 1);
      end
    join
    hold(1'b1, 20);
    drain("t1_drain", 50);
    check("t1_ferr", ferr_seen, 0);
    check("t1_ovr", ovr_seen, 0);

    // Short low glitch on an idle line.
    hold(1'b0, 6);
    check("t2_busy", rx_busy, 1);
    hold(1'b1, 9);
    check("t2_idle", rx_busy, 0);
    hold(1'b1, 30);
    check("t2_ferr", ferr_seen, 0);

    // Framing error followed by a held-low break.
    send_frame(8'h3C, 1'b0, -1);
    hold(1'b0, 40);
    check("t3_break_busy", rx_busy, 1);
    check("t3_ferr", ferr_seen, 1);
    hold(1'b1, 20);
    check("t3_break_exit", rx_busy, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1);
    hold(1'b1, 20);
    drain("t3_drain", 50);
    check("t3_ferr_once", ferr_seen, 1);

    // Fill to overflow with the consumer stalled.
    axis.tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, -1);
    end
    hold(1'b1, 5);
    check("t4_ovr", ovr_seen, 1);
    check("t4_tvalid", axis.tvalid, 1);
    check("t4_head", axis.tdata, 8'h00);

    // Push into a full FIFO in the same cycle as a pop.
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1, -1);
      begin
        repeat (157) @(posedge clk);
        #1;
        axis.tready = 1'b1;
      end
    join
    hold(1'b1, 10);
    drain("t5_drain", 100);
    check("t5_ovr", ovr_seen, 1);

    // Back-to-back frames, one with an in-bit glitch.
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    send_frame(8'hFF, 1'b1, 3);
    send_frame(8'h00, 1'b1, -1);
    hold(1'b1, 20);
    drain("t6_drain", 50);
    check("t6_ferr", ferr_seen, 1);

    // Reset mid-frame with a byte waiting and the line low across release.
    axis.tready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1);
    hold(1'b1, 5);
    check("t7_pending", axis.tvalid, 1);
    hold(1'b0, 50);
    rst_n = 1'b0;
    #1;
    check("t7_rst_tvalid", axis.tvalid, 0);
    check("t7_rst_busy", rx_busy, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b0, 30);
    check("t7_low_ignored", rx_busy, 0);
    check("t7_no_stale", axis.tvalid, 0);
    axis.tready = 1'b1;
    hold(1'b1, 20);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, -1);
    hold(1'b1, 20);
    drain("t7_drain", 50);
    check("t7_ferr", ferr_seen, 1);
    check("t7_ovr", ovr_seen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
